// File: rtl/multiport_register_file.sv
// Integer register file for the ID stage: N combinational read ports, M clocked write ports,
// write-to-read bypass, hardwired x0, post-reset clear sweep and a pending-destination scoreboard.
module multiport_register_file #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned REG_MEM_ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD_PORTS       = 2,
  parameter int unsigned NUM_WR_PORTS       = 1,
  parameter int unsigned CLEAR_ON_RESET     = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_RD_PORTS*REG_MEM_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]         rd_data_o,
  output logic [NUM_RD_PORTS-1:0]                    rd_busy_o,
  input  logic [NUM_WR_PORTS-1:0]                    wr_en_i,
  input  logic [NUM_WR_PORTS*REG_MEM_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]         wr_data_i,
  input  logic                                       sb_set_en_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0]              sb_set_addr_i,
  input  logic                                       sb_flush_i,
  output logic                                       init_busy_o
);

  localparam int unsigned AW       = REG_MEM_ADDR_WIDTH;
  localparam int unsigned DW       = DATA_WIDTH;
  localparam int unsigned NUM_REGS = 1 << AW;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e              state_q;
  logic [AW-1:0]       cnt_q;
  logic                init_busy_q;

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  logic                accept_en;
  logic                sweep_we;
  logic [NUM_WR_PORTS-1:0] wr_acc;
  logic [AW-1:0]       wr_addr [NUM_WR_PORTS];
  logic [DW-1:0]       wr_data [NUM_WR_PORTS];

  assign accept_en   = (state_q == ST_READY) && !rst;
  assign sweep_we    = (state_q == ST_CLEAR) && !rst;
  assign init_busy_o = init_busy_q;

  for (genvar j = 0; j < NUM_WR_PORTS; j++) begin : g_wr
    assign wr_addr[j] = wr_addr_i[j*AW +: AW];
    assign wr_data[j] = wr_data_i[j*DW +: DW];
    assign wr_acc[j]  = accept_en && wr_en_i[j] && (wr_addr[j] != '0);
  end

  // Sweep sequencer: counter walks every entry once, then hands over to normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state_q     <= ST_CLEAR;
        init_busy_q <= 1'b1;
      end else begin
        state_q     <= ST_READY;
        init_busy_q <= 1'b0;
      end
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == {AW{1'b1}}) begin
        state_q     <= ST_READY;
        init_busy_q <= 1'b0;
      end
    end
  end

  // NOTE: the array has no reset branch on purpose; the sweep zeroes it one entry per cycle,
  // so it maps onto plain RAM/flops without a reset net. Later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      regs_q[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR_PORTS; j++) begin
        if (wr_acc[j]) regs_q[wr_addr[j]] <= wr_data[j];
      end
    end
  end

  // NOTE: every always_comb output is given a default on entry so no path can infer a latch.
  always_comb begin
    pending_d = pending_q;
    for (int j = 0; j < NUM_WR_PORTS; j++) begin
      if (wr_acc[j]) pending_d[wr_addr[j]] = 1'b0;
    end
    // A same-cycle issue belongs to a newer producer than the retiring write, so set wins.
    if (accept_en && sb_set_en_i && (sb_set_addr_i != '0)) pending_d[sb_set_addr_i] = 1'b1;
    if (sb_flush_i) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;

    assign addr = rd_addr_i[k*AW +: AW];

    always_comb begin
      data = regs_q[addr];
      busy = pending_q[addr];
      for (int j = 0; j < NUM_WR_PORTS; j++) begin
        if (wr_acc[j] && (wr_addr[j] == addr)) begin
          data = wr_data[j];
          busy = 1'b0;
        end
      end
      if ((state_q != ST_READY) || (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data_o[k*DW +: DW] = data;
    assign rd_busy_o[k]          = busy;
  end

endmodule
